rob_pr_free_q: RTL

ROB_PR_FREE_Q -- requirements
Module: rob_pr_free_q

---
 rtl/rob_pr_free_q.sv | 108 ++++++++++
 1 files changed

// File: rtl/rob_pr_free_q.sv
// Commit-side queue of freed physical registers, fanned out one PR per free-list bank per cycle.
// Define ROB_PR_FREE_Q_STATS_EN to build the saturating enqueue-stall counter; otherwise stat_stall_count is tied to 0.
module rob_pr_free_q #(
  parameter int PR_COUNT              = 128,
  parameter int LOG_PR_COUNT          = 7,
  parameter int PRF_BANK_COUNT        = 4,
  parameter int ROB_PR_FREE_Q_ENTRIES = 2
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic [3:0]                                    enq_valid_by_lane,
  input  logic [3:0][LOG_PR_COUNT-1:0]                  enq_PR_by_lane,
  output logic                                          enq_ready,
  output logic [PRF_BANK_COUNT-1:0]                     deq_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   deq_PR_by_bank,
  output logic [15:0]                                   stat_stall_count
);

  localparam int LANES   = 4;
  localparam int ENTRIES = ROB_PR_FREE_Q_ENTRIES;
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = $clog2(ENTRIES + 1);
  localparam int BANK_W  = $clog2(PRF_BANK_COUNT);

  if (PR_COUNT > (1 << LOG_PR_COUNT)) begin : g_pr_tag_chk
    $error("PR_COUNT does not fit in LOG_PR_COUNT bits");
  end

  // PR payload is never reset: it is only visible through pending lanes.
  logic [LANES-1:0][LOG_PR_COUNT-1:0] pr_q [ENTRIES];
  logic [LANES-1:0]                   pend_q [ENTRIES];
  logic [PTR_W-1:0]                   head_q, tail_q;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;

  logic             full, empty, enq_fire, pop;
  logic [LANES-1:0] head_pend, emit_mask, pend_left;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CNT_W'(ENTRIES));
  assign empty     = (cnt_q == '0);
  assign enq_ready = !full;
  assign enq_fire  = (|enq_valid_by_lane) && !full;
  assign head_pend = pend_q[head_q];

  // Each bank takes the lowest-index pending head lane that maps to it.
  always_comb begin
    emit_mask         = '0;
    deq_valid_by_bank = '0;
    deq_PR_by_bank    = '0;
    if (!empty) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        for (int l = 0; l < LANES; l++) begin
          if (!deq_valid_by_bank[b] && head_pend[l] &&
              (pr_q[head_q][l][BANK_W-1:0] == BANK_W'(b))) begin
            deq_valid_by_bank[b] = 1'b1;
            deq_PR_by_bank[b]    = pr_q[head_q][l];
            emit_mask[l]         = 1'b1;
          end
        end
      end
    end
  end

  assign pend_left = head_pend & ~emit_mask;
  assign pop       = !empty && (pend_left == '0);
  assign cnt_d     = cnt_q + CNT_W'(enq_fire) - CNT_W'(pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) pend_q[i] <= '0;
    end else begin
      if (!empty) pend_q[head_q] <= pend_left;
      if (enq_fire) begin
        pend_q[tail_q] <= enq_valid_by_lane;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_fire) pr_q[tail_q] <= enq_PR_by_lane;
  end

`ifdef ROB_PR_FREE_Q_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if ((|enq_valid_by_lane) && full && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_stall_count = stall_q;
`else
  assign stat_stall_count = '0;
`endif

endmodule
